// File: rtl/param_calculator_fsm_pkg.sv
// Shared types and key-code constants for the fixed-point keypad calculator.
package param_calculator_fsm_pkg;

    localparam int unsigned BTN_W         = 10;
    localparam int unsigned BTN_CLEAR_BIT = 7;

    localparam logic [1:0] BTN_KIND_DIG_LO = 2'b00;
    localparam logic [1:0] BTN_KIND_DIG_HI = 2'b01;
    localparam logic [1:0] BTN_KIND_OP     = 2'b10;
    localparam logic [1:0] BTN_KIND_CTRL   = 2'b11;

    typedef enum logic [2:0] {
        S_ENTRY_A,
        S_OP_WAIT,
        S_ENTRY_B,
        S_COMPUTE,
        S_DIVIDE,
        S_SHOW,
        S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        OP_NONE = 3'd0,
        OP_ADD  = 3'd1,
        OP_SUB  = 3'd2,
        OP_MUL  = 3'd3,
        OP_DIV  = 3'd4
    } op_t;

    function automatic logic onehot8(input logic [7:0] v);
        return (v != 8'd0) && ((v & (v - 8'd1)) == 8'd0);
    endfunction

    function automatic logic [2:0] enc8(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/param_calculator_fsm_divider.sv
// Restoring divider: one quotient bit per cycle over a 2*DATA_W-bit dividend.
module calc_divider #(
    parameter int unsigned DATA_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [2*DATA_W-1:0]   i_dividend,
    input  logic [DATA_W-1:0]     i_divisor,
    output logic                  o_done,
    output logic [2*DATA_W-1:0]   o_quotient
);

    localparam int unsigned QW    = 2 * DATA_W;
    localparam int unsigned CNT_W = $clog2(QW + 1);

    logic [DATA_W-1:0] r_rem;
    logic [QW-1:0]     r_quo;
    logic [DATA_W-1:0] r_div;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_busy;
    logic              r_done;

    logic [DATA_W-1:0] w_src_rem;
    logic [QW-1:0]     w_src_quo;
    logic [DATA_W-1:0] w_src_div;
    logic [DATA_W:0]   w_shift;
    logic              w_fit;
    logic [DATA_W-1:0] w_rem_nxt;
    logic [QW-1:0]     w_quo_nxt;

    // The first step runs on the start edge straight from the inputs.
    always_comb begin
        w_src_rem = i_start ? '0 : r_rem;
        w_src_quo = i_start ? i_dividend : r_quo;
        w_src_div = i_start ? i_divisor : r_div;
        w_shift   = {w_src_rem, w_src_quo[QW-1]};
        w_fit     = (w_shift >= {1'b0, w_src_div});
        w_rem_nxt = w_fit ? DATA_W'(w_shift - {1'b0, w_src_div}) : DATA_W'(w_shift);
        w_quo_nxt = {w_src_quo[QW-2:0], w_fit};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (i_abort) begin
                r_busy <= 1'b0;
                r_cnt  <= '0;
            end else if (i_start) begin
                r_rem  <= w_rem_nxt;
                r_quo  <= w_quo_nxt;
                r_div  <= i_divisor;
                r_cnt  <= CNT_W'(QW - 1);
                r_busy <= 1'b1;
            end else if (r_busy) begin
                r_rem <= w_rem_nxt;
                r_quo <= w_quo_nxt;
                r_cnt <= r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    r_busy <= 1'b0;
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign o_done     = r_done;
    assign o_quotient = r_quo;

endmodule

// File: rtl/param_calculator_fsm.sv
// Keypad-driven fixed-point calculator: entry/operator FSM with saturating ALU and iterative divider.
module param_calculator_fsm
    import param_calculator_fsm_pkg::*;
#(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned FRAC_DIGITS  = 2,
    parameter int unsigned ENTRY_DIGITS = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [BTN_W-1:0]         button,
    output logic                     clear,
    output logic                     equal,
    output logic [3:0]               button_num,
    output logic [2:0]               button_op,
    output logic signed [DATA_W-1:0] result_temp,
    output logic signed [DATA_W-1:0] result,
    output logic                     busy,
    output logic                     err_div0,
    output logic                     err_ovf
);

    localparam int unsigned WW    = 2 * DATA_W;
    localparam int unsigned SCALE = 10 ** FRAC_DIGITS;
    localparam int unsigned CNT_W = $clog2(ENTRY_DIGITS + 1);

    localparam logic signed [DATA_W-1:0] MAX_N   = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] MIN_N   = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [WW-1:0]     MAX_W   = WW'(MAX_N);
    localparam logic signed [WW-1:0]     MIN_W   = WW'(MIN_N);
    localparam logic signed [WW-1:0]     SCALE_W = WW'(SCALE);
    localparam logic signed [DATA_W-1:0] TEN_S   = DATA_W'(10);

    state_t                    r_state, w_state_nxt;
    op_t                       r_op, w_op_nxt;
    op_t                       r_pend_op, w_pend_nxt;
    logic signed [DATA_W-1:0]  r_result, w_result_nxt;
    logic signed [DATA_W-1:0]  r_temp, w_temp_nxt;
    logic [CNT_W-1:0]          r_digits, w_digits_nxt;
    logic                      r_err_div0, w_err_div0_nxt;
    logic                      r_err_ovf, w_err_ovf_nxt;
    logic                      r_clear, w_clear_nxt;
    logic                      r_equal, w_equal_nxt;
    logic [3:0]                r_button_num, w_button_num_nxt;
    logic                      r_busy;
    logic [BTN_W-1:0]          r_btn_prev;

    logic                      w_press;
    logic                      w_is_digit, w_is_op, w_is_clear, w_is_equal;
    logic [3:0]                w_digit;
    op_t                       w_op;
    logic                      w_key_digit, w_key_op, w_key_equal;

    logic signed [WW-1:0]      w_a_w, w_b_w, w_alu, w_div_s, w_wide;
    logic signed [DATA_W-1:0]  w_sat, w_temp_acc;
    logic                      w_ovf;
    logic [DATA_W-1:0]         w_a_mag, w_b_mag;
    logic [WW-1:0]             w_dividend, w_quo;
    logic                      w_div_start, w_div_abort, w_div_done;
    logic                      w_finish;

    // Key decode: only a zero-to-code transition with exactly one bit in its field counts.
    always_comb begin
        w_press    = (r_btn_prev == '0) && (button != '0);
        w_is_digit = 1'b0;
        w_is_op    = 1'b0;
        w_is_clear = 1'b0;
        w_is_equal = 1'b0;
        w_digit    = 4'd0;
        w_op       = OP_NONE;
        case (button[9:8])
            BTN_KIND_DIG_LO: begin
                if (onehot8(button[7:0])) begin
                    w_is_digit = 1'b1;
                    w_digit    = {1'b0, enc8(button[7:0])};
                end
            end
            BTN_KIND_DIG_HI: begin
                if (button[7:0] == 8'h01) begin
                    w_is_digit = 1'b1;
                    w_digit    = 4'd8;
                end else if (button[7:0] == 8'h02) begin
                    w_is_digit = 1'b1;
                    w_digit    = 4'd9;
                end
            end
            BTN_KIND_OP: begin
                if ((button[7:4] == 4'd0) && onehot8(button[7:0])) begin
                    w_is_op = 1'b1;
                    case (button[3:0])
                        4'b0001: w_op = OP_ADD;
                        4'b0010: w_op = OP_SUB;
                        4'b0100: w_op = OP_MUL;
                        default: w_op = OP_DIV;
                    endcase
                end
            end
            default: begin
                if (button[BTN_CLEAR_BIT]) w_is_clear = 1'b1;
                else                       w_is_equal = 1'b1;
            end
        endcase
        w_key_digit = w_press && w_is_digit;
        w_key_op    = w_press && w_is_op;
        w_key_equal = w_press && w_is_equal;
    end

    // Datapath: wide intermediates, then saturation back to DATA_W.
    always_comb begin
        w_a_w      = WW'(r_result);
        w_b_w      = WW'(r_temp);
        w_a_mag    = r_result[DATA_W-1] ? DATA_W'(-r_result) : DATA_W'(r_result);
        w_b_mag    = r_temp[DATA_W-1] ? DATA_W'(-r_temp) : DATA_W'(r_temp);
        w_dividend = WW'(w_a_mag) * WW'(SCALE);
        w_temp_acc = DATA_W'(r_temp * TEN_S) + DATA_W'(w_digit);
        case (r_op)
            OP_ADD:  w_alu = w_a_w + w_b_w;
            OP_SUB:  w_alu = w_a_w - w_b_w;
            OP_MUL:  w_alu = (w_a_w * w_b_w) / SCALE_W;
            default: w_alu = w_a_w;
        endcase
        w_div_s = (r_result[DATA_W-1] ^ r_temp[DATA_W-1]) ? -$signed(w_quo) : $signed(w_quo);
        w_wide  = (r_state == S_DIVIDE) ? w_div_s : w_alu;
        w_ovf   = (w_wide > MAX_W) || (w_wide < MIN_W);
        if (w_wide > MAX_W)      w_sat = MAX_N;
        else if (w_wide < MIN_W) w_sat = MIN_N;
        else                     w_sat = w_wide[DATA_W-1:0];
    end

    calc_divider #(
        .DATA_W (DATA_W)
    ) u_div (
        .clk        (clk),
        .rst        (rst),
        .i_start    (w_div_start),
        .i_abort    (w_div_abort),
        .i_dividend (w_dividend),
        .i_divisor  (w_b_mag),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    // Next-state and register updates.
    always_comb begin
        w_state_nxt      = r_state;
        w_op_nxt         = r_op;
        w_pend_nxt       = r_pend_op;
        w_result_nxt     = r_result;
        w_temp_nxt       = r_temp;
        w_digits_nxt     = r_digits;
        w_err_div0_nxt   = r_err_div0;
        w_err_ovf_nxt    = r_err_ovf;
        w_button_num_nxt = r_button_num;
        w_clear_nxt      = w_press && w_is_clear;
        w_equal_nxt      = 1'b0;
        w_div_start      = 1'b0;
        w_div_abort      = 1'b0;
        w_finish         = 1'b0;

        if (w_press && w_is_clear) begin
            w_state_nxt    = S_ENTRY_A;
            w_op_nxt       = OP_NONE;
            w_pend_nxt     = OP_NONE;
            w_result_nxt   = '0;
            w_temp_nxt     = '0;
            w_digits_nxt   = '0;
            w_err_div0_nxt = 1'b0;
            w_err_ovf_nxt  = 1'b0;
            w_div_abort    = 1'b1;
        end else begin
            case (r_state)
                S_ENTRY_A: begin
                    w_equal_nxt = w_key_equal;
                    if (w_key_digit) begin
                        w_button_num_nxt = w_digit;
                        if (r_digits < CNT_W'(ENTRY_DIGITS)) begin
                            w_temp_nxt   = w_temp_acc;
                            w_digits_nxt = r_digits + CNT_W'(1);
                        end
                    end else if (w_key_op) begin
                        w_result_nxt = r_temp;
                        w_op_nxt     = w_op;
                        w_temp_nxt   = '0;
                        w_digits_nxt = '0;
                        w_state_nxt  = S_OP_WAIT;
                    end
                end
                S_OP_WAIT: begin
                    w_equal_nxt = w_key_equal;
                    if (w_key_digit) begin
                        w_button_num_nxt = w_digit;
                        w_temp_nxt       = DATA_W'(w_digit);
                        w_digits_nxt     = CNT_W'(1);
                        w_state_nxt      = S_ENTRY_B;
                    end else if (w_key_op) begin
                        w_op_nxt = w_op;
                    end
                end
                S_ENTRY_B: begin
                    w_equal_nxt = w_key_equal;
                    if (w_key_digit) begin
                        w_button_num_nxt = w_digit;
                        if (r_digits < CNT_W'(ENTRY_DIGITS)) begin
                            w_temp_nxt   = w_temp_acc;
                            w_digits_nxt = r_digits + CNT_W'(1);
                        end
                    end else if (w_key_op || w_key_equal) begin
                        w_pend_nxt = w_key_op ? w_op : OP_NONE;
                        if (r_op == OP_DIV) begin
                            if (r_temp == '0) begin
                                w_err_div0_nxt = 1'b1;
                                w_result_nxt   = '0;
                                w_state_nxt    = S_ERROR;
                            end else begin
                                w_div_start = 1'b1;
                                w_state_nxt = S_DIVIDE;
                            end
                        end else begin
                            w_state_nxt = S_COMPUTE;
                        end
                    end
                end
                S_SHOW: begin
                    w_equal_nxt = w_key_equal;
                    if (w_key_digit) begin
                        w_button_num_nxt = w_digit;
                        w_temp_nxt       = DATA_W'(w_digit);
                        w_digits_nxt     = CNT_W'(1);
                        w_state_nxt      = S_ENTRY_A;
                    end else if (w_key_op) begin
                        w_op_nxt    = w_op;
                        w_state_nxt = S_OP_WAIT;
                    end
                end
                S_COMPUTE: w_finish = 1'b1;
                S_DIVIDE:  w_finish = w_div_done;
                default:   ;
            endcase

            // Commit a completed operation; an overflow always lands in SHOW.
            if (w_finish) begin
                w_result_nxt  = w_sat;
                w_err_ovf_nxt = r_err_ovf | w_ovf;
                w_temp_nxt    = '0;
                w_digits_nxt  = '0;
                if (w_ovf || (r_pend_op == OP_NONE)) begin
                    w_state_nxt = S_SHOW;
                end else begin
                    w_state_nxt = S_OP_WAIT;
                end
                if (r_pend_op != OP_NONE) w_op_nxt = r_pend_op;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_ENTRY_A;
            r_op         <= OP_NONE;
            r_pend_op    <= OP_NONE;
            r_result     <= '0;
            r_temp       <= '0;
            r_digits     <= '0;
            r_err_div0   <= 1'b0;
            r_err_ovf    <= 1'b0;
            r_clear      <= 1'b0;
            r_equal      <= 1'b0;
            r_button_num <= 4'd0;
            r_busy       <= 1'b0;
            r_btn_prev   <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_op         <= w_op_nxt;
            r_pend_op    <= w_pend_nxt;
            r_result     <= w_result_nxt;
            r_temp       <= w_temp_nxt;
            r_digits     <= w_digits_nxt;
            r_err_div0   <= w_err_div0_nxt;
            r_err_ovf    <= w_err_ovf_nxt;
            r_clear      <= w_clear_nxt;
            r_equal      <= w_equal_nxt;
            r_button_num <= w_button_num_nxt;
            r_busy       <= (w_state_nxt == S_COMPUTE) || (w_state_nxt == S_DIVIDE);
            r_btn_prev   <= button;
        end
    end

    assign clear       = r_clear;
    assign equal       = r_equal;
    assign button_num  = r_button_num;
    assign button_op   = r_op;
    assign result_temp = r_temp;
    assign result      = r_result;
    assign busy        = r_busy;
    assign err_div0    = r_err_div0;
    assign err_ovf     = r_err_ovf;

endmodule

// File: doc/param_calculator_fsm.md
PARAM_CALCULATOR_FSM -- requirements
Module: param_calculator_fsm

Interface
REQ-001 Parameter DATA_W, default 16: signed width of the operand, accumulator and result registers.
REQ-002 Parameter FRAC_DIGITS, default 2: decimal fraction digits; every value is stored as an integer scaled by SCALE = 10^FRAC_DIGITS.
REQ-003 Parameter ENTRY_DIGITS, default 4: maximum number of digits per operand entry.
REQ-004 Ports, clock and reset first:
  clk  in  1  single clock; all state on rising edge.
  rst  in  1  asynchronous, active-high reset.
  button  in  10  key code: [9:8]=00 digit one-hot [7:0]=0..7; 01 with [0]=8, [1]=9; 10 operator one-hot [3:0]=add,sub,mul,div; 11 with [7]=1 clear, otherwise equal.
  clear  out  1  decoded clear key, registered pulse.
  equal  out  1  decoded equal key, registered pulse.
  button_num  out  4  last decoded digit.
  button_op  out  3  last decoded operator: 0 none, 1 add, 2 sub, 3 mul, 4 div.
  result_temp  out  DATA_W signed  operand being entered.
  result  out  DATA_W signed  accumulator / displayed result.
  busy  out  1  computation in progress.
  err_div0  out  1  sticky divide-by-zero flag.
  err_ovf  out  1  sticky overflow flag.

Function
REQ-005 A keypress is the transition of button from zero to a valid non-zero code; a held code counts once; invalid codes (not exactly one bit set in the field) are ignored.
REQ-006 States: ENTRY_A, OP_WAIT, ENTRY_B, COMPUTE, DIVIDE, SHOW, ERROR.
REQ-007 Digit in ENTRY_A or ENTRY_B: result_temp <= result_temp*10 + d; digits beyond ENTRY_DIGITS are ignored.
REQ-008 Digit in SHOW or OP_WAIT: result_temp <= d; next state ENTRY_B from OP_WAIT, ENTRY_A from SHOW.
REQ-009 Operator in ENTRY_A: result <= result_temp, op latched, result_temp <= 0, go OP_WAIT; operator in OP_WAIT replaces the latched op.
REQ-010 Operator in SHOW: op latched, go OP_WAIT (chain from result).
REQ-011 Operator or equal in ENTRY_B: go COMPUTE (DIVIDE for div); on completion result updated, result_temp <= 0, then OP_WAIT on operator (new op latched) or SHOW on equal.
REQ-012 Add/sub/mul complete in one COMPUTE cycle; mul = (a*b)/SCALE, 2*DATA_W-bit intermediate, truncated toward zero.
REQ-013 Div = (a*SCALE)/b on magnitudes, one quotient bit per cycle, 2*DATA_W cycles, sign applied afterwards, truncated toward zero.
REQ-014 busy is high in COMPUTE and DIVIDE; all keys except clear are ignored while busy.
REQ-015 A result outside the DATA_W signed range saturates to max/min and sets err_ovf; the state then goes to SHOW.
REQ-016 Div with b=0 sets err_div0, result <= 0, and enters ERROR; only clear or reset leaves ERROR.
REQ-017 Clear in any state, including mid-DIVIDE: result, result_temp, op and both error flags are zeroed, busy drops next cycle, go ENTRY_A.
REQ-018 Equal in ENTRY_A, OP_WAIT or SHOW: no effect.

Reset
REQ-019 On rst, immediately: state ENTRY_A; result, result_temp, button_num, button_op all 0; clear, equal, busy, err_div0, err_ovf all 0.
REQ-020 The divider counter and operands are reset too; no residual busy after rst is released.

Structure
REQ-021 A shared package holds the state enumeration, the op codes (NONE, ADD, SUB, MUL, DIV) and the button field constants.
REQ-022 The iterative divider is a sub-module, calc_divider, with a start/done handshake, parameterised by DATA_W.

Verification
REQ-023 5,2,5 sub 7,2,5 equal -> result -200; then div 2,0,0 equal -> result -100.
REQ-024 5,2,5 add 3,2,5 equal -> 850; clear -> result 0, state ENTRY_A.
REQ-025 5,0,0 sub 3,2,5 add 2,2,5 equal (chain) -> intermediate 175, final 400.
REQ-026 6,0,0 div 3,0,0 equal -> busy for 32 cycles, result 200; mul 8,0,0 equal -> 1600.
REQ-027 9,9,9,9 mul 9,9,9,9 equal -> result 32767, err_ovf=1; 1,0,0 div 0 equal -> err_div0=1, ERROR, further keys ignored until clear.
REQ-028 rst asserted mid-DIVIDE -> all outputs 0 asynchronously; held digit key for 5 cycles -> one digit entered.
